// File: rtl/store_buffer.sv
// ============================================================================
// Module   : store_buffer
// Brief    : Post-commit store queue that drains to the dcache over req/ack
//            and forwards to younger loads. Optional macro SB_COALESCE_EN
//            merges a word store into the youngest non-head entry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq_valid,
    input  logic [ADDR_W-1:0]        enq_addr,
    input  logic [DATA_W-1:0]        enq_data,
    input  logic                     enq_byte,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic                     ld_byte,
    output logic                     ld_hit,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     ld_stall,
    output logic                     dc_req,
    output logic [ADDR_W-1:0]        dc_addr,
    output logic [DATA_W-1:0]        dc_data,
    output logic                     dc_byte,
    input  logic                     dc_ack
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [ADDR_W-1:0]  r_addr [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [DEPTH-1:0]   r_byte;
    logic [DEPTH-1:0]   r_valid;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_coal;

    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

`ifdef SB_COALESCE_EN
    logic [c_PTR_W-1:0] w_tail_m1;
    assign w_tail_m1 = r_tail - c_PTR_W'(1);
    // The head is always on the dcache port when non-empty, so it is never merged into.
    assign w_coal = enq_valid && !enq_byte && !w_empty && (w_tail_m1 != r_head) &&
                    (r_addr[w_tail_m1][ADDR_W-1:2] == enq_addr[ADDR_W-1:2]);
`else
    assign w_coal = 1'b0;
`endif

    assign w_push = enq_valid && !w_full && !w_coal;
    assign w_pop  = dc_ack && !w_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
            r_byte  <= '0;
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_addr[r_tail]  <= enq_addr;
                r_data[r_tail]  <= enq_data;
                r_byte[r_tail]  <= enq_byte;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + c_PTR_W'(1);
            end
`ifdef SB_COALESCE_EN
            if (w_coal) begin
                r_data[w_tail_m1] <= enq_data;
                r_byte[w_tail_m1] <= 1'b0;
            end
`endif
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Walk oldest to youngest so the youngest matching entry has the last word.
    always_comb begin
        logic [c_PTR_W-1:0] w_idx;
        logic [7:0]         w_sel;
        ld_hit   = 1'b0;
        ld_stall = 1'b0;
        ld_data  = '0;
        w_idx    = '0;
        w_sel    = '0;
        if (ld_valid) begin
            for (int k = 0; k < DEPTH; k++) begin
                w_idx = r_head + c_PTR_W'(k);
                if (r_valid[w_idx] && (r_addr[w_idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
                    if (!r_byte[w_idx]) begin
                        w_sel    = r_data[w_idx][{ld_addr[1:0], 3'b000} +: 8];
                        ld_hit   = 1'b1;
                        ld_stall = 1'b0;
                        ld_data  = ld_byte ? {{(DATA_W-8){1'b0}}, w_sel} : r_data[w_idx];
                    end else if (!ld_byte) begin
                        ld_hit   = 1'b0;
                        ld_stall = 1'b1;
                        ld_data  = '0;
                    end else if (r_addr[w_idx][1:0] == ld_addr[1:0]) begin
                        ld_hit   = 1'b1;
                        ld_stall = 1'b0;
                        ld_data  = {{(DATA_W-8){1'b0}}, r_data[w_idx][7:0]};
                    end
                end
            end
        end
    end

    assign full    = w_full;
    assign empty   = w_empty;
    assign count   = r_count;
    assign dc_req  = !w_empty;
    assign dc_addr = r_addr[r_head];
    assign dc_data = r_data[r_head];
    assign dc_byte = r_byte[r_head];

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// Module   : tb_store_buffer
// Brief    : Directed self-checking bench for store_buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        enq_valid;
    logic [31:0] enq_addr;
    logic [31:0] enq_data;
    logic        enq_byte;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_byte;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        dc_req;
    logic [31:0] dc_addr;
    logic [31:0] dc_data;
    logic        dc_byte;
    logic        dc_ack;

    int checks;
    int errors;

    store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_addr(enq_addr), .enq_data(enq_data), .enq_byte(enq_byte),
        .full(full), .empty(empty), .count(count),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_byte(ld_byte),
        .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_data(dc_data), .dc_byte(dc_byte),
        .dc_ack(dc_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_enq(input logic [31:0] a, input logic [31:0] d, input logic b);
        enq_valid = 1'b1;
        enq_addr  = a;
        enq_data  = d;
        enq_byte  = b;
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full got %0b exp 0", full); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL reset_empty got %0b exp 1", empty); end
        checks++; if (count !== 3'd0)    begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (dc_req !== 1'b0)   begin errors++; $display("FAIL reset_dc_req got %0b exp 0", dc_req); end
        ld_valid = 1'b1; ld_addr = 32'h100; ld_byte = 1'b0;
        #1;
        checks++; if (ld_hit !== 1'b0 || ld_stall !== 1'b0 || ld_data !== 32'h0)
            begin errors++; $display("FAIL reset_probe got hit=%0b stall=%0b data=%h exp 0/0/0", ld_hit, ld_stall, ld_data); end
        ld_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_enq_async_reset();
        do_enq(32'h100, 32'hDEADBEEF, 1'b0);
        checks++; if (dc_req !== 1'b1)          begin errors++; $display("FAIL enq_dc_req got %0b exp 1", dc_req); end
        checks++; if (dc_addr !== 32'h100)      begin errors++; $display("FAIL enq_dc_addr got %h exp 00000100", dc_addr); end
        checks++; if (dc_data !== 32'hDEADBEEF) begin errors++; $display("FAIL enq_dc_data got %h exp deadbeef", dc_data); end
        checks++; if (count !== 3'd1 || empty !== 1'b0)
            begin errors++; $display("FAIL enq_count got count=%0d empty=%0b exp 1/0", count, empty); end
        tick();
        checks++; if (dc_addr !== 32'h100)      begin errors++; $display("FAIL hold_dc_addr got %h exp 00000100", dc_addr); end
        #3;
        reset  = 1'b0;
        dc_ack = 1'b1;
        #1;
        checks++; if (count !== 3'd0 || dc_req !== 1'b0)
            begin errors++; $display("FAIL async_reset got count=%0d dc_req=%0b exp 0/0", count, dc_req); end
        tick();
        tick();
        dc_ack = 1'b0;
        reset  = 1'b1;
        tick();
        checks++; if (empty !== 1'b1 || count !== 3'd0)
            begin errors++; $display("FAIL post_reset got empty=%0b count=%0d exp 1/0", empty, count); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) do_enq(32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
        checks++; if (full !== 1'b1 || count !== 3'd4)
            begin errors++; $display("FAIL fill_full got full=%0b count=%0d exp 1/4", full, count); end
        do_enq(32'h20, 32'hBAD, 1'b0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_reject got count=%0d exp 4", count); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (dc_addr !== 32'h10 + 32'(4 * i) || dc_data !== 32'hA0 + 32'(i))
                begin errors++; $display("FAIL drain_order_%0d got %h=%h exp %h=%h", i, dc_addr, dc_data, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i)); end
            dc_ack = 1'b1;
            tick();
            dc_ack = 1'b0;
        end
        checks++; if (empty !== 1'b1 || dc_req !== 1'b0)
            begin errors++; $display("FAIL drain_empty got empty=%0b dc_req=%0b exp 1/0", empty, dc_req); end
    endtask

    task automatic test_full_ack();
        for (int i = 0; i < 4; i++) do_enq(32'h40 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0);
        enq_valid = 1'b1; enq_addr = 32'h50; enq_data = 32'hBAD; enq_byte = 1'b0;
        dc_ack = 1'b1;
        tick();
        enq_valid = 1'b0;
        dc_ack = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_ack_count got %0d exp 3", count); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (dc_addr !== 32'h40 + 32'(4 * i))
                begin errors++; $display("FAIL full_ack_order_%0d got %h exp %h", i, dc_addr, 32'h40 + 32'(4 * i)); end
            dc_ack = 1'b1;
            tick();
            dc_ack = 1'b0;
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_ack_empty got %0b exp 1", empty); end
    endtask

    task automatic test_forward_word();
        // Entry being enqueued this cycle is not yet visible.
        enq_valid = 1'b1; enq_addr = 32'h200; enq_data = 32'h11223344; enq_byte = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h200; ld_byte = 1'b0;
        #1;
        checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL fwd_same_cycle got hit=%0b exp 0", ld_hit); end
        tick();
        enq_valid = 1'b0;
        ld_addr = 32'h201; ld_byte = 1'b1;
        #1;
        checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h33)
            begin errors++; $display("FAIL fwd_ldb got hit=%0b data=%h exp 1/00000033", ld_hit, ld_data); end
        ld_valid = 1'b0;
        #1;
        checks++; if (ld_hit !== 1'b0 || ld_stall !== 1'b0)
            begin errors++; $display("FAIL fwd_idle got hit=%0b stall=%0b exp 0/0", ld_hit, ld_stall); end
        do_enq(32'h200, 32'hAABBCCDD, 1'b0);
        ld_valid = 1'b1; ld_addr = 32'h200; ld_byte = 1'b0;
        #1;
        checks++; if (ld_hit !== 1'b1 || ld_data !== 32'hAABBCCDD)
            begin errors++; $display("FAIL fwd_youngest got hit=%0b data=%h exp 1/aabbccdd", ld_hit, ld_data); end
        ld_addr = 32'h203; ld_byte = 1'b1;
        #1;
        checks++; if (ld_data !== 32'hAA) begin errors++; $display("FAIL fwd_ldb_hi got %h exp 000000aa", ld_data); end
        ld_valid = 1'b0;
        dc_ack = 1'b1;
        tick();
        // Last entry is popped this cycle but must still forward.
        ld_valid = 1'b1; ld_addr = 32'h200; ld_byte = 1'b0;
        #1;
        checks++; if (ld_hit !== 1'b1 || ld_data !== 32'hAABBCCDD)
            begin errors++; $display("FAIL fwd_popping got hit=%0b data=%h exp 1/aabbccdd", ld_hit, ld_data); end
        tick();
        dc_ack = 1'b0;
        ld_valid = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fwd_drained got %0b exp 1", empty); end
    endtask

    task automatic test_byte_store();
        do_enq(32'h302, 32'hFFFFFF7F, 1'b1);
        ld_valid = 1'b1; ld_addr = 32'h300; ld_byte = 1'b0;
        #1;
        checks++; if (ld_stall !== 1'b1 || ld_hit !== 1'b0)
            begin errors++; $display("FAIL byte_ldw got stall=%0b hit=%0b exp 1/0", ld_stall, ld_hit); end
        ld_addr = 32'h302; ld_byte = 1'b1;
        #1;
        checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h7F || ld_stall !== 1'b0)
            begin errors++; $display("FAIL byte_ldb got hit=%0b data=%h stall=%0b exp 1/0000007f/0", ld_hit, ld_data, ld_stall); end
        ld_addr = 32'h303;
        #1;
        checks++; if (ld_hit !== 1'b0 || ld_stall !== 1'b0)
            begin errors++; $display("FAIL byte_other got hit=%0b stall=%0b exp 0/0", ld_hit, ld_stall); end
        ld_valid = 1'b0;
        checks++; if (dc_byte !== 1'b1) begin errors++; $display("FAIL byte_dc_byte got %0b exp 1", dc_byte); end
        dc_ack = 1'b1;
        tick();
        dc_ack = 1'b0;
    endtask

    task automatic test_coalesce();
        logic [2:0]  exp_cnt;
        logic [31:0] exp_second;
`ifdef SB_COALESCE_EN
        exp_cnt    = 3'd2;
        exp_second = 32'd2;
`else
        exp_cnt    = 3'd3;
        exp_second = 32'd1;
`endif
        do_enq(32'h100, 32'h5, 1'b0);
        do_enq(32'h400, 32'h1, 1'b0);
        do_enq(32'h400, 32'h2, 1'b0);
        checks++; if (count !== exp_cnt) begin errors++; $display("FAIL coal_count got %0d exp %0d", count, exp_cnt); end
        ld_valid = 1'b1; ld_addr = 32'h400; ld_byte = 1'b0;
        #1;
        checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h2)
            begin errors++; $display("FAIL coal_probe got hit=%0b data=%h exp 1/00000002", ld_hit, ld_data); end
        ld_valid = 1'b0;
        dc_ack = 1'b1;
        tick();
        dc_ack = 1'b0;
        checks++; if (dc_addr !== 32'h400 || dc_data !== exp_second)
            begin errors++; $display("FAIL coal_second got %h=%h exp 00000400=%h", dc_addr, dc_data, exp_second); end
        for (int i = 0; i < 8 && dc_req; i++) begin
            dc_ack = 1'b1;
            tick();
            dc_ack = 1'b0;
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL coal_drain got %0b exp 1", empty); end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0;
        enq_valid = 1'b0; enq_addr = '0; enq_data = '0; enq_byte = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_byte = 1'b0;
        dc_ack = 1'b0;
        test_reset();
        test_enq_async_reset();
        test_fill_drain();
        test_full_ack();
        test_forward_word();
        test_byte_store();
        test_coalesce();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
